// File: rtl/key_onehot_if.sv
// Key capture bus: raw key lines and ack in, captured one-hot code and status out.
interface key_onehot_if;
   logic [7:0] key_raw;
   logic       ack;
   logic [7:0] y_out;
   logic       en_out;
   logic       busy;
   logic       overrun;

   modport master (
      output key_raw, ack,
      input  y_out, en_out, busy, overrun
   );

   modport slave (
      input  key_raw, ack,
      output y_out, en_out, busy, overrun
   );
endinterface

// File: rtl/key_onehot_capture.sv
// Synchronises and debounces eight push-buttons and captures one press at a time
// as a one-hot word with enable, held until the consumer acknowledges it.
module key_onehot_capture #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input logic        clk,
   input logic        rst,
   key_onehot_if.slave bus
);

   localparam int unsigned N_KEYS = 8;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      WAIT_REL = 2'd2
   } state_t;

   logic [N_KEYS-1:0] sync1;
   logic [N_KEYS-1:0] key_s;
   logic [N_KEYS-1:0] db;
   logic [N_KEYS-1:0] db_d;
   logic [N_KEYS-1:0] pe;
   logic [N_KEYS-1:0] pick;
   logic [CNT_W-1:0]  cnt [N_KEYS];

   state_t            state;
   state_t            state_nxt;
   logic [N_KEYS-1:0] y_q;
   logic [N_KEYS-1:0] y_nxt;
   logic              en_q;
   logic              en_nxt;
   logic              busy_q;
   logic              busy_nxt;
   logic              ovr_q;
   logic              ovr_nxt;

   // Two-flop synchroniser on the asynchronous key lines
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         key_s <= '0;
      end else begin
         sync1 <= bus.key_raw;
         key_s <= sync1;
      end
   end

   // Per-key stability counter; the debounced state flips only after a full run of disagreement
   always_ff @(posedge clk) begin
      if (rst) begin
         db   <= '0;
         db_d <= '0;
         for (int i = 0; i < int'(N_KEYS); i++) begin
            cnt[i] <= '0;
         end
      end else begin
         db_d <= db;
         for (int i = 0; i < int'(N_KEYS); i++) begin
            if (key_s[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               db[i]  <= ~db[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign pe = db & ~db_d;

   // Highest-index press edge wins when several arrive together
   always_comb begin
      pick = '0;
      for (int i = 0; i < int'(N_KEYS); i++) begin
         if (pe[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         y_q    <= '0;
         en_q   <= 1'b0;
         busy_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         y_q    <= y_nxt;
         en_q   <= en_nxt;
         busy_q <= busy_nxt;
         ovr_q  <= ovr_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (|pe) state_nxt = HOLD;
         HOLD:     if (bus.ack) state_nxt = (|db) ? WAIT_REL : IDLE;
         WAIT_REL: if (~|db) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Output next values; edges seen while busy are dropped but flagged
   always_comb begin
      y_nxt    = y_q;
      en_nxt   = en_q;
      ovr_nxt  = ovr_q | ((state != IDLE) & (|pe));
      busy_nxt = (state_nxt != IDLE);
      case (state)
         IDLE: begin
            if (|pe) begin
               y_nxt  = pick;
               en_nxt = 1'b1;
            end
         end
         HOLD: begin
            if (bus.ack) begin
               y_nxt  = '0;
               en_nxt = 1'b0;
            end
         end
         WAIT_REL: begin
            y_nxt  = '0;
            en_nxt = 1'b0;
         end
         default: begin
            y_nxt  = '0;
            en_nxt = 1'b0;
         end
      endcase
   end

   assign bus.y_out   = y_q;
   assign bus.en_out  = en_q;
   assign bus.busy    = busy_q;
   assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture with a short debounce window.
module tb_key_onehot_capture;

   localparam int unsigned DC = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   key_onehot_if bus ();

   key_onehot_capture #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] key;
      logic [7:0] exp_y;
      logic [2:0] exp_a;
   } vec_t;

   vec_t walk [8];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_en(input string name, input int max);
      int n = 0;
      while (bus.en_out !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      chk(name, 32'(bus.en_out), 32'd1);
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while (bus.busy !== 1'b0 && n < max) begin
         tick();
         n++;
      end
      chk(name, 32'(bus.busy), 32'd0);
   endtask

   task automatic ack_pulse();
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
   endtask

   // Model of the downstream 8-to-3 encoder
   function automatic logic [2:0] enc(input logic [7:0] y);
      enc = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) enc = 3'(i);
      end
   endfunction

   initial begin
      logic [10:0] bounce;

      walk[0] = '{8'h80, 8'h80, 3'd7};
      walk[1] = '{8'h40, 8'h40, 3'd6};
      walk[2] = '{8'h20, 8'h20, 3'd5};
      walk[3] = '{8'h10, 8'h10, 3'd4};
      walk[4] = '{8'h08, 8'h08, 3'd3};
      walk[5] = '{8'h04, 8'h04, 3'd2};
      walk[6] = '{8'h02, 8'h02, 3'd1};
      walk[7] = '{8'h01, 8'h01, 3'd0};

      rst         = 1'b1;
      bus.key_raw = 8'h00;
      bus.ack     = 1'b0;
      tick();
      tick();
      chk("rst_y",    32'(bus.y_out),   32'h0);
      chk("rst_en",   32'(bus.en_out),  32'h0);
      chk("rst_busy", 32'(bus.busy),    32'h0);
      chk("rst_ovr",  32'(bus.overrun), 32'h0);
      rst = 1'b0;

      // 1: single press latency, ack, release
      bus.key_raw = 8'h20;
      repeat (6) tick();
      chk("t1_en_early", 32'(bus.en_out), 32'd0);
      tick();
      chk("t1_en",   32'(bus.en_out), 32'd1);
      chk("t1_y",    32'(bus.y_out),  32'h20);
      chk("t1_busy", 32'(bus.busy),   32'd1);
      ack_pulse();
      chk("t1_ack_en",   32'(bus.en_out), 32'd0);
      chk("t1_ack_y",    32'(bus.y_out),  32'h0);
      chk("t1_ack_busy", 32'(bus.busy),   32'd1);
      bus.key_raw = 8'h00;
      wait_idle("t1_idle", 20);

      // 2: bounce on key 3 never reaches the debounced state
      bounce = 11'b111_00_111_000;
      for (int i = 10; i >= 0; i--) begin
         bus.key_raw = bounce[i] ? 8'h08 : 8'h00;
         tick();
         chk("t2_bounce_en", 32'(bus.en_out), 32'd0);
      end
      repeat (4) begin
         tick();
         chk("t2_bounce_y", 32'(bus.y_out), 32'h0);
      end
      bus.key_raw = 8'h08;
      wait_en("t2_en", 12);
      chk("t2_y", 32'(bus.y_out), 32'h08);
      ack_pulse();
      bus.key_raw = 8'h00;
      wait_idle("t2_idle", 20);

      // 3: simultaneous press resolves to highest key, waits for full release
      bus.key_raw = 8'h81;
      wait_en("t3_en", 12);
      chk("t3_y",   32'(bus.y_out),   32'h80);
      chk("t3_ovr", 32'(bus.overrun), 32'd0);
      ack_pulse();
      repeat (8) tick();
      chk("t3_wait_busy", 32'(bus.busy),   32'd1);
      chk("t3_wait_en",   32'(bus.en_out), 32'd0);
      bus.key_raw = 8'h00;
      wait_idle("t3_idle", 20);
      chk("t3_ovr_end", 32'(bus.overrun), 32'd0);

      // 4: press during HOLD sets sticky overrun and is dropped
      bus.key_raw = 8'h02;
      wait_en("t4_en", 12);
      chk("t4_y", 32'(bus.y_out), 32'h02);
      bus.key_raw = 8'h42;
      repeat (8) tick();
      chk("t4_ovr",   32'(bus.overrun), 32'd1);
      chk("t4_hold_y", 32'(bus.y_out),  32'h02);
      chk("t4_hold_en", 32'(bus.en_out), 32'd1);
      ack_pulse();
      bus.key_raw = 8'h00;
      wait_idle("t4_idle", 20);
      repeat (10) tick();
      chk("t4_no_cap_en", 32'(bus.en_out),  32'd0);
      chk("t4_no_cap_y",  32'(bus.y_out),   32'h0);
      chk("t4_ovr_stick", 32'(bus.overrun), 32'd1);

      // 5: reset during HOLD with key still held gives a fresh capture
      bus.key_raw = 8'h10;
      wait_en("t5_en", 12);
      chk("t5_y", 32'(bus.y_out), 32'h10);
      rst = 1'b1;
      tick();
      chk("t5_rst_y",    32'(bus.y_out),   32'h0);
      chk("t5_rst_en",   32'(bus.en_out),  32'h0);
      chk("t5_rst_busy", 32'(bus.busy),    32'h0);
      chk("t5_rst_ovr",  32'(bus.overrun), 32'h0);
      rst = 1'b0;
      repeat (6) tick();
      chk("t5_en_early", 32'(bus.en_out), 32'd0);
      tick();
      chk("t5_en2", 32'(bus.en_out), 32'd1);
      chk("t5_y2",  32'(bus.y_out),  32'h10);
      ack_pulse();
      bus.key_raw = 8'h00;
      wait_idle("t5_idle", 20);

      // 6: walk keys 7..0
      for (int k = 0; k < 8; k++) begin
         bus.key_raw = walk[k].key;
         wait_en("t6_en", 12);
         chk("t6_y", 32'(bus.y_out), 32'(walk[k].exp_y));
         chk("t6_a", 32'(enc(bus.y_out)), 32'(walk[k].exp_a));
         ack_pulse();
         bus.key_raw = 8'h00;
         wait_idle("t6_idle", 20);
      end
      chk("t6_ovr", 32'(bus.overrun), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
